instr_feeder: RTL
=================

// Module: instr_feeder
// PURPOSE
//  Upstream stage of the simple processor: holds a small program in local memory and issues it
//  one instruction at a time over the processor's run/din/done handshake.
//  Each word is driven on din with a one-cycle run pulse. The next word is issued only after done.
//  Stops on a halt word, on end of memory, or on a done-timeout.
// PARAMETERS
//  DEPTH      16       program memory words (power of 2, >=2); AW = $clog2(DEPTH)
//  HALT_WORD  16'hFFFF instruction value that ends the program; it is never issued
//  TIMEOUT    64       max cycles in WAIT without done before aborting (>=2)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  load_en      in   1   write load_data to mem[load_addr]; honoured only when busy=0
//  load_addr    in   AW  program write address
//  load_data    in   16  program word (op[15:13] I[12] rX[11:9] imm/rY[8:0])
//  start        in   1   one-cycle pulse: run program from address 0; ignored while busy
//  done         in   1   processor completion, from processor.done
//  run          out  1   one-cycle issue strobe, to processor.run
//  din          out  16  instruction word, to processor.din; held stable from issue until done
//  busy         out  1   1 in FETCH/ISSUE/WAIT
//  halted       out  1   program ended; sticky until start or reset
//  timeout_err  out  1   sticky: WAIT exceeded TIMEOUT; cleared by start or reset
//  pc           out  AW  address of the current/last issued word
//  issued_cnt   out  8   words issued since start, saturates at 255
// BEHAVIOUR
//  Reset (sync): state=IDLE; run=0, din=0, busy=0, halted=0, timeout_err=0, pc=0, issued_cnt=0.
//    Memory contents are not reset. Reset mid-program drops run immediately; no further issue.
//  States: IDLE, FETCH, ISSUE, WAIT, HALT.
//  IDLE:  start -> pc=0, issued_cnt=0, halted=0, timeout_err=0, go to FETCH.
//  FETCH: synchronous read of mem[pc]; word available next cycle.
//  ISSUE: if word==HALT_WORD -> HALT (no run). Otherwise din<=word, run=1 for exactly this cycle,
//         issued_cnt+1 (saturating), wdog=0, go to WAIT.
//  WAIT:  run=0, din held, wdog increments each cycle.
//         done=1 and pc==DEPTH-1 -> HALT. The pc does not wrap.
//         done=1 otherwise -> pc+1, go to FETCH.
//         wdog reaches TIMEOUT-1 with done=0 -> timeout_err=1, go to HALT.
//         done and timeout in the same cycle: done wins.
//  HALT:  halted=1, busy=0. start -> restart exactly as from IDLE; load_en accepted.
//  Latency: start sampled at edge k -> FETCH in cycle k+1 -> run=1 in cycle k+2.
//    Per instruction, done seen at edge j -> next run=1 in cycle j+2.
//  done is sampled only in WAIT; done in IDLE/FETCH/ISSUE/HALT is ignored.
//    done coincident with the run cycle does not complete that instruction.
//  load_en while busy=1 is dropped; no memory change.
//    load_en and start in the same idle cycle: the write occurs, and the program starts next cycle.
//    The FETCH read reflects the write if load_addr==0.
//  start while busy=1 is ignored.
// STRUCTURE
//  Shared package feeder_pkg holds:
//    - state enum {IDLE,FETCH,ISSUE,WAIT,HALT}
//    - HALT_WORD default
//    - instruction field constants: OP_MSB=15, OP_LSB=13, IMM_BIT=12, RX_MSB=11, RX_LSB=9
//  One sub-module, feeder_imem: DEPTH x 16 single-port RAM with synchronous read and write.
//    Write is enabled only when not busy.
//  FSM, watchdog, pc and counters live in instr_feeder.
// TESTING  (processor model asserts done 3 cycles after run unless stated)
//  1 Load 10FF,20FF,40FF,60FF,FFFF at 0..4, pulse start ->
//    4 run pulses, din=10FF/20FF/40FF/60FF, each held until done; then halted=1, issued_cnt=4, pc=4.
//  2 Timeout: same program, model never asserts done (TIMEOUT=64) ->
//    one run pulse with din=10FF; 64 cycles later timeout_err=1, halted=1, issued_cnt=1.
//  3 DEPTH=4 with no halt word, words 0001..0004 ->
//    4 issues, halted after 4th done, pc=3, no 5th run.
//  4 load_en to addr 1 with data 1234 while in WAIT ->
//    ignored; rerun shows din=20FF at addr 1. done in the run cycle -> not counted, still waits.
//  5 Sync reset asserted in WAIT of 2nd instruction ->
//    next cycle run=0, din=0, busy=0, pc=0; start reruns the program from 10FF.
//  6 start pulsed again while busy -> no effect on pc or issued_cnt.
//    start in HALT -> clean restart, halted=0.

Source files
------------

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared types and constants for the instruction feeder.
// FSM states, default halt word and instruction field layout.
package feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    HALT
  } state_t;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] HALT_WORD_DEF = 16'hFFFF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int IMM_BIT = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 9;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/feeder_imem.sv
// feeder_imem: single-port program RAM, synchronous read and write.
// Writes are locked out while the feeder is running a program.
module feeder_imem
  import feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              busy,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Program write when idle; registered read when fetching.
  always_ff @(posedge clk) begin
    if (we && !busy) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: issues a stored program over the run/din/done handshake.
// Stops on the halt word, at the last memory word, or on a done timeout.
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter logic [WORD_W-1:0] HALT_WORD = HALT_WORD_DEF,
  parameter int TIMEOUT = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              start,
  input  logic              done,
  output logic              run,
  output logic [WORD_W-1:0] din,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err,
  output logic [AW-1:0]     pc,
  output logic [7:0]        issued_cnt
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_t state;
  state_t state_nx;

  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] din_r;
  logic [AW-1:0]     mem_addr;
  logic [WW-1:0]     wdog;
  logic [7:0]        cnt;
  logic              terr;

  logic clr;
  logic fetch;
  logic issue;
  logic adv;
  logic tmo;
  logic is_halt;
  logic pc_last;
  logic wd_last;

  assign is_halt = (word == HALT_WORD);
  assign pc_last = (pc == PC_LAST);
  assign wd_last = (wdog == WD_LAST);

  assign busy = (state == FETCH) ||
                (state == ISSUE) ||
                (state == WAIT);

  assign mem_addr = busy ? pc : load_addr;

  feeder_imem #(
    .DEPTH(DEPTH)
  ) u_imem (
    .clk  (clk),
    .busy (busy),
    .we   (load_en),
    .re   (fetch),
    .addr (mem_addr),
    .wdata(load_data),
    .rdata(word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    fetch    = 1'b0;
    issue    = 1'b0;
    adv      = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        fetch    = 1'b1;
        state_nx = ISSUE;
      end
      ISSUE: begin
        if (is_halt) begin
          state_nx = HALT;
        end else begin
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          if (pc_last) begin
            state_nx = HALT;
          end else begin
            adv      = 1'b1;
            state_nx = FETCH;
          end
        end else if (wd_last) begin
          tmo      = 1'b1;
          state_nx = HALT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // pc, issued word, counters, watchdog and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      din_r <= '0;
      cnt   <= '0;
      wdog  <= '0;
      terr  <= 1'b0;
    end else begin
      if (clr) begin
        pc   <= '0;
        cnt  <= '0;
        terr <= 1'b0;
      end
      if (adv) begin
        pc <= pc + AW'(1);
      end
      if (issue) begin
        din_r <= word;
        cnt   <= sat_inc(cnt);
        wdog  <= '0;
      end
      if (state == WAIT) begin
        wdog <= wdog + WW'(1);
      end
      if (tmo) begin
        terr <= 1'b1;
      end
    end
  end

  assign run         = issue;
  assign din         = issue ? word : din_r;
  assign halted      = (state == HALT);
  assign timeout_err = terr;
  assign issued_cnt  = cnt;

endmodule
